// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable single-port scratch RAM.
// Latency: n/a (types/functions only); backpressure: n/a.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int RDW_READ_OLD   = 0;
    localparam int RDW_WRITE_THRU = 1;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_sp_clr_core.sv
// Bare RAM array: one write port, one registered read port, read-during-write mux.
// Latency: 1 cycle read (re at edge N -> rdata/rvalid after N+1); backpressure: none.
module ram_sp_clr_core
    import ram_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = RDW_READ_OLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-old falls out of NBA ordering; write-through needs an explicit bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                if (RDW_MODE == RDW_WRITE_THRU && we && waddr == raddr) begin
                    rdata <= wdata;
                end else begin
                    rdata <= mem[raddr];
                end
            end
        end
    end

endmodule

// File: rtl/ram_sp_clr.sv
// Scratch RAM with post-reset/on-request clear sequencer; RAM_PARITY_EN adds per-word parity and perr.
// Latency: 1 cycle read; backpressure: none, busy=1 for DEPTH cycles while the clear owns the array.
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0,
    parameter int                RDW_MODE = RDW_READ_OLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
`ifdef RAM_PARITY_EN
    ,
    output logic              perr
`endif
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    logic [MEM_W-1:0]  mem_wword;
    logic              mem_re;
    logic [MEM_W-1:0]  mem_rword;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // The clear pass takes the write port; user traffic only reaches the array in IDLE.
    assign mem_we    = busy | we;
    assign mem_waddr = busy ? cnt_q : waddr;
    assign mem_wdat  = busy ? CLR_VAL : wdata;
    assign mem_re    = ~busy & re;

`ifdef RAM_PARITY_EN
    assign mem_wword = {even_par(64'(mem_wdat)), mem_wdat};
    assign perr      = rvalid & (mem_rword[DATA_W] != even_par(64'(mem_rword[DATA_W-1:0])));
`else
    assign mem_wword = mem_wdat;
`endif

    assign rdata = mem_rword[DATA_W-1:0];

    ram_sp_clr_core #(
        .WIDTH    (MEM_W),
        .ADDR_W   (ADDR_W),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wword),
        .re     (mem_re),
        .raddr  (raddr),
        .rdata  (mem_rword),
        .rvalid (rvalid)
    );

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: two instances (read-old/clear 0x00, write-through/clear 0xA5) on shared stimulus.
module tb_ram_sp_clr;

    localparam logic [7:0] CLR_A = 8'h00;
    localparam logic [7:0] CLR_B = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req, we, re;
    logic [5:0] waddr, raddr;
    logic [7:0] wdata;
    logic       busy_a, busy_b, rvalid_a, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
`ifdef RAM_PARITY_EN
    logic       perr_a, perr_b;
`endif

    always #5 clk = ~clk;

    ram_sp_clr #(.DATA_W(8), .ADDR_W(6), .CLR_VAL(CLR_A), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
`ifdef RAM_PARITY_EN
        , .perr(perr_a)
`endif
    );

    ram_sp_clr #(.DATA_W(8), .ADDR_W(6), .CLR_VAL(CLR_B), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
`ifdef RAM_PARITY_EN
        , .perr(perr_b)
`endif
    );

    typedef struct {
        bit         w;
        logic [5:0] wa;
        logic [7:0] wd;
        bit         r;
        logic [5:0] ra;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    vec_t       tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one cycle, then checks the response at the following negedge.
    task automatic step(input vec_t v);
        logic [7:0] e;
        we = v.w; waddr = v.wa; wdata = v.wd;
        re = v.r; raddr = v.ra;
        if (v.r) begin
            q_a.push_back(v.ea);
            q_b.push_back(v.eb);
        end
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        if (v.r) begin
            chk("rvalid_a", 64'(rvalid_a), 64'd1);
            chk("rvalid_b", 64'(rvalid_b), 64'd1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("rdata_a", 64'(rdata_a), 64'(e));
                last_a = e;
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("rdata_b", 64'(rdata_b), 64'(e));
                last_b = e;
            end
        end else begin
            chk("rvalid_a_low", 64'(rvalid_a), 64'd0);
            chk("rvalid_b_low", 64'(rvalid_b), 64'd0);
            chk("rdata_a_hold", 64'(rdata_a), 64'(last_a));
            chk("rdata_b_hold", 64'(rdata_b), 64'(last_b));
        end
    endtask

    // Counts clock edges until busy falls; with junk set, hammers we/re/clr_req meanwhile.
    task automatic wait_clear(input bit junk, input string nm);
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 200) begin
            if (junk) begin
                chk("rvalid_a_busy", 64'(rvalid_a), 64'd0);
                chk("rvalid_b_busy", 64'(rvalid_b), 64'd0);
                we = 1'b1; waddr = 6'd7; wdata = 8'hFF;
                re = 1'b1; raddr = 6'd7; clr_req = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        chk(nm, 64'(n), 64'd64);
        chk("busy_a_low", 64'(busy_a), 64'd0);
        chk("busy_b_low", 64'(busy_b), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr_req = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_a", 64'(busy_a), 64'd1);
        chk("rst_busy_b", 64'(busy_b), 64'd1);
        chk("rst_rvalid_a", 64'(rvalid_a), 64'd0);
        chk("rst_rdata_a", 64'(rdata_a), 64'd0);
        chk("rst_rdata_b", 64'(rdata_b), 64'd0);
`ifdef RAM_PARITY_EN
        chk("rst_perr_a", 64'(perr_a), 64'd0);
`endif
        rst_n = 1'b1;
        wait_clear(1'b0, "busy_len_reset");

        for (int a = 0; a < 64; a++) begin
            step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'(a), ea:CLR_A, eb:CLR_B});
        end

        tbl[0]  = '{w:1'b1, wa:6'd7, wd:8'h3C, r:1'b0, ra:6'd0, ea:8'h00, eb:8'h00};
        tbl[1]  = '{w:1'b1, wa:6'd5, wd:8'h11, r:1'b0, ra:6'd0, ea:8'h00, eb:8'h00};
        tbl[2]  = '{w:1'b1, wa:6'd5, wd:8'h22, r:1'b1, ra:6'd5, ea:8'h11, eb:8'h22};
        tbl[3]  = '{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd5, ea:8'h22, eb:8'h22};
        for (int i = 0; i < 4; i++) begin
            tbl[4+i] = '{w:1'b1, wa:6'(i), wd:8'(8'h10 + i), r:1'b0, ra:6'd0, ea:8'h00, eb:8'h00};
            tbl[8+i] = '{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'(i), ea:8'(8'h10 + i), eb:8'(8'h10 + i)};
        end
        tbl[12] = '{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd7, ea:8'h3C, eb:8'h3C};
        tbl[13] = '{w:1'b0, wa:6'd0, wd:8'h00, r:1'b0, ra:6'd0, ea:8'h00, eb:8'h00};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i]);
        end

        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        chk("clr_busy_a", 64'(busy_a), 64'd1);
        wait_clear(1'b1, "busy_len_clr");
        step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd7, ea:CLR_A, eb:CLR_B});
        step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd5, ea:CLR_A, eb:CLR_B});

        step('{w:1'b1, wa:6'd2, wd:8'h5A, r:1'b0, ra:6'd0, ea:8'h00, eb:8'h00});
        re = 1'b1; raddr = 6'd2;
        @(posedge clk);
        #1;
        chk("midread_rvalid", 64'(rvalid_a), 64'd1);
        chk("midread_rdata", 64'(rdata_a), 64'h5A);
        re = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid_a", 64'(rvalid_a), 64'd0);
        chk("arst_rdata_a", 64'(rdata_a), 64'd0);
        chk("arst_rdata_b", 64'(rdata_b), 64'd0);
        chk("arst_busy_a", 64'(busy_a), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        last_a = 8'h00;
        last_b = 8'h00;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst30_busy_b", 64'(busy_b), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(1'b0, "busy_len_rst30");
        step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd2, ea:CLR_A, eb:CLR_B});

`ifdef RAM_PARITY_EN
        dut_a.u_core.mem[9][8] = ~dut_a.u_core.mem[9][8];
        step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd9, ea:CLR_A, eb:CLR_B});
        chk("perr_a_hit", 64'(perr_a), 64'd1);
        chk("perr_b_clean", 64'(perr_b), 64'd0);
        step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b1, ra:6'd10, ea:CLR_A, eb:CLR_B});
        chk("perr_a_next", 64'(perr_a), 64'd0);
        step('{w:1'b0, wa:6'd0, wd:8'h00, r:1'b0, ra:6'd0, ea:8'h00, eb:8'h00});
        chk("perr_a_idle", 64'(perr_a), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
